// File: rtl/ahbl_loadable_rom_pkg.sv
// ahbl_loadable_rom_pkg: loader FSM states and AHB-Lite constants shared by the loadable ROM
package ahbl_loadable_rom_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} ld_state_t;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam int BYTE_LANES = 4;
endpackage

// File: rtl/ahbl_loadable_rom_ld_word_packer.sv
// ld_word_packer: assembles little-endian loader bytes into 32-bit words, lane 0 first
module ld_word_packer
  import ahbl_loadable_rom_pkg::*;
(
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    clr,
  input  logic                    en,
  input  logic [7:0]              data,
  output logic [8*BYTE_LANES-1:0] word,
  output logic                    word_valid,
  output logic                    partial
);
  localparam int IW = $clog2(BYTE_LANES);
  logic [IW-1:0] byte_idx;
  logic [8*BYTE_LANES-1:0] acc;
  // word shows the incoming byte merged in, so a completed word can be stored the same cycle
  always_comb begin
    word = acc;
    if (en) word[8*byte_idx +: 8] = data;
  end
  assign word_valid = en && byte_idx == IW'(BYTE_LANES - 1);
  assign partial = byte_idx != '0;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      byte_idx <= '0;
      acc <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      acc <= '0;
    end else if (en) begin
      byte_idx <= byte_idx + IW'(1);
      acc <= word_valid ? '0 : word;
    end
endmodule

// File: rtl/ahbl_loadable_rom.sv
// ahbl_loadable_rom: AHB-Lite ROM with read wait states, write-error response and a clear-then-load byte loader
module ahbl_loadable_rom
  import ahbl_loadable_rom_pkg::*;
#(
  parameter  int SIZE        = 65536,
  parameter  int WAIT_STATES = 0,
  localparam int DEPTH       = SIZE / 4,
  localparam int AW          = $clog2(DEPTH)
)(
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic          ld_start,
  input  logic          ld_end,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done,
  output logic          ld_ovf,
  output logic [AW:0]   ld_words
);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  ld_state_t state, state_n;
  logic [AW:0] ptr;
  logic [31:0] mem [DEPTH];
  logic [31:0] word, wd;
  logic word_valid, partial, we, start, clr_last, full, take, flush, sel, rd_pend, err, unused_ok;
  logic [2:0] cnt;
  logic [AW-1:0] rd_addr, rd_idx;

  assign unused_ok = ^{HWDATA, HADDR[31:AW+2], HADDR[1:0]};
  assign full = ptr[AW];
  assign clr_last = ptr[AW-1:0] == '1;
  assign ld_ready = state == LOAD;
  assign ld_busy = state != IDLE;
  assign ld_done = state == DONE;
  assign start = state == IDLE && ld_start;
  assign take = ld_ready && ld_valid && !full;
  assign flush = ld_done && partial;
  assign we = state == CLEAR || word_valid || flush;
  assign wd = state == CLEAR ? '0 : word;

  ld_word_packer u_packer (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .clr        (start),
    .en         (take),
    .data       (ld_data),
    .word       (word),
    .word_valid (word_valid),
    .partial    (partial)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ld_start ? CLEAR : IDLE;
      CLEAR:   state_n = clr_last ? LOAD : CLEAR;
      LOAD:    state_n = ld_end ? DONE : LOAD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= IDLE;
    else state <= state_n;

  // ptr sweeps the array during CLEAR, then restarts as the load write pointer
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      ptr <= '0;
      ld_words <= '0;
      ld_ovf <= 1'b0;
    end else if (start) begin
      ptr <= '0;
      ld_words <= '0;
      ld_ovf <= 1'b0;
    end else begin
      if (state == CLEAR) ptr <= clr_last ? '0 : ptr + ONE;
      else if (word_valid || flush) begin
        ptr <= ptr + ONE;
        ld_words <= ld_words + ONE;
      end
      if (ld_ready && ld_valid && full) ld_ovf <= 1'b1;
    end

  always_ff @(posedge HCLK)
    if (we) mem[ptr[AW-1:0]] <= wd;

  assign sel = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign rd_idx = rd_pend ? rd_addr : HADDR[AW+1:2];

  // a pending read is frozen while the loader owns the array, then runs its wait states
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      rd_pend <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      rd_addr <= '0;
      HREADYOUT <= 1'b1;
      HRESP <= HRESP_OKAY;
      HRDATA <= '0;
    end else if (rd_pend) begin
      if (state == IDLE && cnt < 3'd2) begin
        HRDATA <= mem[rd_idx];
        HREADYOUT <= 1'b1;
        rd_pend <= 1'b0;
      end else if (state == IDLE) cnt <= cnt - 3'd1;
    end else if (err) begin
      err <= 1'b0;
      HREADYOUT <= 1'b1;
    end else if (sel && HWRITE) begin
      err <= 1'b1;
      HREADYOUT <= 1'b0;
      HRESP <= HRESP_ERROR;
    end else if (sel && WAIT_STATES == 0 && state == IDLE) begin
      HRDATA <= mem[rd_idx];
      HREADYOUT <= 1'b1;
      HRESP <= HRESP_OKAY;
    end else if (sel) begin
      rd_pend <= 1'b1;
      rd_addr <= HADDR[AW+1:2];
      cnt <= 3'(WAIT_STATES);
      HREADYOUT <= 1'b0;
      HRESP <= HRESP_OKAY;
    end else begin
      HREADYOUT <= 1'b1;
      HRESP <= HRESP_OKAY;
    end
endmodule

// File: tb/tb_ahbl_loadable_rom.sv
// tb_ahbl_loadable_rom: vector table, corner sequences and random traffic against a byte-level memory model
module tb_ahbl_loadable_rom;
  localparam int SIZE = 16;
  localparam int WS = 2;
  localparam int DEPTH = SIZE / 4;

  logic HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, hready_en = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0] HTRANS = '0;
  logic HREADY, HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic ld_start = 1'b0, ld_end = 1'b0, ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic ld_ready, ld_busy, ld_done, ld_ovf;
  logic [2:0] ld_words;

  assign HREADY = HREADYOUT & hready_en;
  always #5 HCLK = ~HCLK;

  ahbl_loadable_rom #(.SIZE(SIZE), .WAIT_STATES(WS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .ld_start(ld_start), .ld_end(ld_end),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_ovf(ld_ovf), .ld_words(ld_words)
  );

  int errors = 0, checks = 0, done_cnt = 0;
  logic [31:0] mem_m [DEPTH];
  logic [2:0] words_m;
  logic ovf_m;

  typedef struct {
    logic sel; logic [1:0] tr; logic wr; logic rdy; logic [31:0] a;
    int lows; logic resp; logic rd;
  } vec_t;
  vec_t tbl [12];

  always @(negedge HCLK) if (ld_done) done_cnt++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task tick;
    @(posedge HCLK);
    #1;
  endtask

  // image after a reload: cleared, then bytes packed little-endian until the array is full
  task automatic model_load(input logic [7:0] q[$]);
    int n;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int i = 0; i < q.size() && i < SIZE; i++) mem_m[i/4][8*(i%4) +: 8] = q[i];
    n = q.size() > SIZE ? SIZE : q.size();
    words_m = 3'((n + 3) / 4);
    ovf_m = q.size() > SIZE;
  endtask

  task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr, input logic rdy,
                      input logic [31:0] a, output int lows, output logic r_low,
                      output logic r_end, output logic [31:0] d);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; hready_en = rdy; HWDATA = $urandom;
    tick;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; hready_en = 1'b1;
    lows = 0; r_low = 1'b0;
    while (!HREADYOUT && lows < 100) begin
      r_low |= HRESP;
      lows++;
      tick;
    end
    r_end = HRESP; d = HRDATA;
  endtask

  task automatic check_mem(input string nm);
    int lows; logic rl, re; logic [31:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b1, 2'b10, 1'b0, 1'b1, 32'(i * 4), lows, rl, re, d);
      chk({nm, "_waits"}, lows, WS);
      chk({nm, "_data"}, d, mem_m[i]);
    end
  endtask

  task automatic check_reset(input string nm);
    chk(nm, {HREADYOUT, HRESP, HRDATA, ld_ready, ld_busy, ld_done, ld_ovf, ld_words},
        {1'b1, 1'b0, 32'h0, 4'h0, 3'h0});
  endtask

  task automatic load(input logic [7:0] q[$], input bit end_with_last, input bit noise);
    int k, d0;
    d0 = done_cnt;
    ld_start = 1'b1; tick; ld_start = 1'b0;
    chk("ovf_cleared", ld_ovf, 0);
    chk("words_cleared", ld_words, 0);
    if (noise) begin ld_end = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE; end
    tick;
    ld_end = 1'b0; ld_valid = 1'b0;
    k = 0;
    while (!ld_ready && k < 100) begin k++; tick; end
    chk("ready_in_load", ld_ready, 1);
    for (int i = 0; i < q.size(); i++) begin
      if (noise) repeat ($urandom_range(0, 2)) begin
        ld_start = ($urandom_range(0, 3) == 0);
        tick;
        ld_start = 1'b0;
      end
      ld_valid = 1'b1; ld_data = q[i]; ld_end = end_with_last && i == q.size() - 1;
      tick;
      ld_valid = 1'b0; ld_end = 1'b0;
    end
    if (!(end_with_last && q.size() > 0)) begin ld_end = 1'b1; tick; ld_end = 1'b0; end
    chk("done_cycle", ld_done, 1);
    tick;
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after", ld_busy, 0);
    model_load(q);
    chk("ld_words", ld_words, words_m);
    chk("ld_ovf", ld_ovf, ovf_m);
  endtask

  initial begin
    int lows, k, viol;
    logic rl, re;
    logic [31:0] d, a;
    logic [7:0] q[$];
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 1'b1, 32'h0,        WS, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 2'b11, 1'b0, 1'b1, 32'h4,        WS, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 1'b1, 32'h8,        0,  1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 1'b1, 1'b1, 32'h8,        0,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 1'b1, 32'hC,        0,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 1'b1, 1'b1, 32'h10,       1,  1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'b10, 1'b0, 1'b1, 32'h10,       WS, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, 1'b1, 32'hFFFFFFFC, WS, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h8,        0,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 1'b1, 1'b1, 32'h4,        0,  1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'b11, 1'b1, 1'b1, 32'h8,        1,  1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 1'b0, 1'b1, 32'h8,        WS, 1'b0, 1'b1};

    tick; tick;
    check_reset("reset_outputs");
    HRESETn = 1'b1;
    tick;

    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load(q, 1'b1, 1'b0);
    check_mem("six_bytes");

    q.delete();
    repeat (SIZE) q.push_back(8'($urandom));
    load(q, 1'b0, 1'b0);
    HRESETn = 1'b0; #2;
    check_reset("idle_reset");
    tick;
    HRESETn = 1'b1;
    tick;
    check_reset("after_reset");

    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].sel, tbl[i].tr, tbl[i].wr, tbl[i].rdy, tbl[i].a, lows, rl, re, d);
      chk($sformatf("vec%0d_waits", i), lows, tbl[i].lows);
      chk($sformatf("vec%0d_resp_wait", i), rl, tbl[i].resp && tbl[i].lows > 0);
      chk($sformatf("vec%0d_resp", i), re, tbl[i].resp);
      if (tbl[i].rd) chk($sformatf("vec%0d_data", i), d, mem_m[tbl[i].a[3:2]]);
    end

    q.delete();
    repeat (SIZE + 1) q.push_back(8'($urandom));
    load(q, 1'b0, 1'b0);
    check_mem("overflow");
    q = '{8'hA1, 8'hB2, 8'hC3};
    load(q, 1'b1, 1'b1);
    check_mem("after_ovf");

    q.delete();
    repeat (7) q.push_back(8'($urandom));
    ld_start = 1'b1; tick; ld_start = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4;
    tick;
    HSEL = 1'b0; HTRANS = 2'b00;
    viol = 0; k = 0;
    while (!ld_ready && k < 100) begin viol += int'(HREADYOUT); k++; tick; end
    for (int i = 0; i < q.size(); i++) begin
      viol += int'(HREADYOUT);
      ld_valid = 1'b1; ld_data = q[i]; ld_end = i == q.size() - 1;
      tick;
      ld_valid = 1'b0; ld_end = 1'b0;
    end
    chk("stall_done", ld_done, 1);
    viol += int'(HREADYOUT);
    tick;
    k = 0;
    while (!HREADYOUT && k < 100) begin k++; tick; end
    model_load(q);
    chk("stall_busy_ready", viol, 0);
    chk("stall_idle_waits", k, WS);
    chk("stall_data", HRDATA, mem_m[1]);
    chk("stall_resp", HRESP, 0);

    q.delete();
    repeat (6) q.push_back(8'($urandom));
    ld_start = 1'b1; tick; ld_start = 1'b0;
    k = 0;
    while (!ld_ready && k < 100) begin k++; tick; end
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_data = q[i];
      tick;
      ld_valid = 1'b0;
    end
    HRESETn = 1'b0; #2;
    check_reset("midload_reset");
    tick;
    HRESETn = 1'b1;
    tick;
    model_load(q[0:3]);
    check_mem("midload_image");

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 5: begin
          a = $urandom;
          xfer(1'b1, 2'($urandom_range(2, 3)), 1'b0, 1'b1, a, lows, rl, re, d);
          chk("rnd_read_waits", lows, WS);
          chk("rnd_read_resp", re, 0);
          chk("rnd_read_data", d, mem_m[a[3:2]]);
        end
        2: begin
          xfer(1'b1, 2'($urandom_range(2, 3)), 1'b1, 1'b1, $urandom, lows, rl, re, d);
          chk("rnd_write_waits", lows, 1);
          chk("rnd_write_resp1", rl, 1);
          chk("rnd_write_resp2", re, 1);
        end
        3: begin
          xfer(1'($urandom), 2'($urandom_range(0, 1)), 1'($urandom), 1'b1, $urandom, lows, rl, re, d);
          chk("rnd_idle_waits", lows, 0);
          chk("rnd_idle_resp", re, 0);
        end
        default: begin
          q.delete();
          repeat ($urandom_range(0, 20)) q.push_back(8'($urandom));
          load(q, 1'($urandom), 1'b1);
        end
      endcase
    end
    check_mem("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
